// File: rtl/ctrl_in_streamer.sv
// ctrl_in_streamer: EP0 control-IN data-stage engine between the request decoder and the usbcorev data_in/data_strobe port.
// Latency: first packet byte is registered on data_in 2 cycles after the EP0 IN transaction_active rise; the next byte is fetched on each data_strobe rise.
// Backpressure: the host paces the transfer. An un-ACKed IN rewinds to the packet start, and EP0 INs are NAKed while idle.
// Ports: clk48mhz/rst (sync, active-low)/usb_rst; start + desc_offset/desc_len/req_len from the decoder;
//        rom_addr/rom_data to the synchronous descriptor ROM; endpoint..success from the core;
//        data_in/data_in_valid/data_toggle/handshake to the core; busy/done status back to the decoder.
module ctrl_in_streamer #(
  parameter int MAX_PKT = 8,
  parameter int ROM_AW  = 8
) (
  input  logic              clk48mhz,
  input  logic              rst,
  input  logic              usb_rst,
  input  logic              start,
  input  logic [ROM_AW-1:0] desc_offset,
  input  logic [7:0]        desc_len,
  input  logic [15:0]       req_len,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic [3:0]        endpoint,
  input  logic              transaction_active,
  input  logic              direction_in,
  input  logic              setup,
  input  logic              data_strobe,
  input  logic              success,
  output logic [7:0]        data_in,
  output logic              data_in_valid,
  output logic              data_toggle,
  output logic [1:0]        handshake,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_PRELOAD,
    S_STREAM,
    S_WAIT_END,
    S_STATUS
  } state_t;

  localparam logic [1:0] HS_ACK = 2'b00;
  localparam logic [1:0] HS_NAK = 2'b10;

  state_t            state_q, state_d;
  logic              ta_q, ds_q;
  logic [ROM_AW-1:0] desc_off_q, desc_off_d;
  logic [7:0]        total_q, total_d;
  logic              need_zlp_q, need_zlp_d;
  logic              zlp_pkt_q, zlp_pkt_d;
  logic [7:0]        pkt_base_q, pkt_base_d;
  logic [7:0]        pkt_cnt_q, pkt_cnt_d;
  logic [7:0]        data_in_q, data_in_d;
  logic              valid_q, valid_d;
  logic              toggle_q, toggle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tx_start, tx_end, strobe_rise, prefetch;
  logic [7:0]        remaining, plen, req_clamp, start_total;
  logic              start_zlp;

  assign tx_start    = transaction_active & ~ta_q & (endpoint == 4'd0);
  assign tx_end      = ~transaction_active & ta_q;
  assign strobe_rise = data_strobe & ~ds_q;

  assign remaining = total_q - pkt_base_q;
  assign plen      = (remaining > 8'(MAX_PKT)) ? 8'(MAX_PKT) : remaining;

  // wLength above 255 can never limit an 8-bit descriptor length, so clamp it first.
  assign req_clamp   = (req_len[15:8] != 8'd0) ? 8'hFF : req_len[7:0];
  assign start_total = (desc_len < req_clamp) ? desc_len : req_clamp;
  // A short-by-exact-multiple transfer needs a ZLP so the host sees the end of data.
  assign start_zlp   = (start_total != 8'd0) &&
                       ((start_total & 8'(MAX_PKT - 1)) == 8'd0) &&
                       ({8'd0, start_total} < req_len);

  // While streaming, the address runs one byte ahead of data_in so that the
  // ROM read latency is hidden. Strobes arrive many cycles apart at full speed.
  assign prefetch = (state_q == S_STREAM);
  assign rom_addr = (state_q == S_IDLE) ? '0 :
                    desc_off_q + ROM_AW'(pkt_base_q) + ROM_AW'(pkt_cnt_q) + ROM_AW'(prefetch);

  assign data_in       = data_in_q;
  assign data_in_valid = valid_q;
  assign data_toggle   = toggle_q;
  assign handshake     = (state_q == S_IDLE) ? HS_NAK : HS_ACK;
  assign busy          = busy_q;
  assign done          = done_q;

  always_ff @(posedge clk48mhz) begin
    if (!rst || usb_rst) begin
      state_q    <= S_IDLE;
      ta_q       <= 1'b0;
      ds_q       <= 1'b0;
      desc_off_q <= '0;
      total_q    <= 8'd0;
      need_zlp_q <= 1'b0;
      zlp_pkt_q  <= 1'b0;
      pkt_base_q <= 8'd0;
      pkt_cnt_q  <= 8'd0;
      data_in_q  <= 8'd0;
      valid_q    <= 1'b0;
      toggle_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ta_q       <= transaction_active;
      ds_q       <= data_strobe;
      desc_off_q <= desc_off_d;
      total_q    <= total_d;
      need_zlp_q <= need_zlp_d;
      zlp_pkt_q  <= zlp_pkt_d;
      pkt_base_q <= pkt_base_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_in_q  <= data_in_d;
      valid_q    <= valid_d;
      toggle_q   <= toggle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    desc_off_d = desc_off_q;
    total_d    = total_q;
    need_zlp_d = need_zlp_q;
    zlp_pkt_d  = zlp_pkt_q;
    pkt_base_d = pkt_base_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_in_d  = data_in_q;
    valid_d    = valid_q;
    toggle_d   = toggle_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          desc_off_d = desc_offset;
          total_d    = start_total;
          need_zlp_d = start_zlp;
          zlp_pkt_d  = 1'b0;
          pkt_base_d = 8'd0;
          pkt_cnt_d  = 8'd0;
          toggle_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_WAIT_IN;
        end
      end

      S_WAIT_IN: begin
        pkt_cnt_d = 8'd0;
        if (tx_start && !setup) begin
          if (!direction_in) begin
            state_d = S_STATUS;
          end else if (remaining != 8'd0) begin
            state_d = S_PRELOAD;
          end else if (need_zlp_q || (total_q == 8'd0)) begin
            valid_d   = 1'b0;
            zlp_pkt_d = 1'b1;
            state_d   = S_WAIT_END;
          end
        end
      end

      // rom_addr was already presented in WAIT_IN, so rom_data holds the first byte.
      S_PRELOAD: begin
        if (tx_end) begin
          valid_d = 1'b0;
          state_d = S_WAIT_IN;
        end else begin
          data_in_d = rom_data;
          valid_d   = 1'b1;
          state_d   = S_STREAM;
        end
      end

      S_STREAM: begin
        if (tx_end) begin
          valid_d   = 1'b0;
          pkt_cnt_d = 8'd0;
          state_d   = S_WAIT_IN;
        end else if (strobe_rise) begin
          if ((pkt_cnt_q + 8'd1) < plen) begin
            data_in_d = rom_data;
            pkt_cnt_d = pkt_cnt_q + 8'd1;
          end else begin
            valid_d   = 1'b0;
            pkt_cnt_d = 8'd0;
            state_d   = S_WAIT_END;
          end
        end
      end

      // Only a handshaken packet advances; a timed-out one is resent unchanged.
      S_WAIT_END: begin
        if (success) begin
          pkt_base_d = pkt_base_q + plen;
          toggle_d   = ~toggle_q;
          if (zlp_pkt_q) need_zlp_d = 1'b0;
          zlp_pkt_d  = 1'b0;
          state_d    = S_WAIT_IN;
        end else if (tx_end) begin
          zlp_pkt_d = 1'b0;
          state_d   = S_WAIT_IN;
        end
      end

      S_STATUS: begin
        if (success) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tx_end) begin
          state_d = S_WAIT_IN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A new SETUP supersedes whatever control transfer was in flight.
    if ((state_q != S_IDLE) && tx_start && setup) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_in_streamer.sv
module tb_ctrl_in_streamer;

  logic        clk48mhz = 1'b0;
  logic        rst = 1'b0;
  logic        usb_rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  desc_offset = 8'd0;
  logic [7:0]  desc_len = 8'd0;
  logic [15:0] req_len = 16'd0;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [3:0]  endpoint = 4'd0;
  logic        transaction_active = 1'b0;
  logic        direction_in = 1'b0;
  logic        setup = 1'b0;
  logic        data_strobe = 1'b0;
  logic        success = 1'b0;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_toggle;
  logic [1:0]  handshake;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rom_mem [256];

  ctrl_in_streamer #(.MAX_PKT(8), .ROM_AW(8)) dut (
    .clk48mhz(clk48mhz), .rst(rst), .usb_rst(usb_rst), .start(start),
    .desc_offset(desc_offset), .desc_len(desc_len), .req_len(req_len),
    .rom_addr(rom_addr), .rom_data(rom_data), .endpoint(endpoint),
    .transaction_active(transaction_active), .direction_in(direction_in),
    .setup(setup), .data_strobe(data_strobe), .success(success),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_toggle(data_toggle),
    .handshake(handshake), .busy(busy), .done(done)
  );

  always #10 clk48mhz = ~clk48mhz;

  // Synchronous descriptor ROM: data valid one cycle after the address.
  always @(posedge clk48mhz) rom_data <= rom_mem[rom_addr];

  function automatic logic [7:0] rom_byte(input int addr);
    return 8'((addr * 5 + 1) & 255);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk48mhz);
  endtask

  task automatic do_start(input logic [7:0] off, input logic [7:0] dlen, input logic [15:0] rlen);
    desc_offset = off; desc_len = dlen; req_len = rlen; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("hs_ack_after_start", handshake, 2'b00);
  endtask

  // One EP0 IN transaction of n bytes starting at ROM address a0; ack selects success vs timeout.
  task automatic in_packet(input int n, input int a0, input logic tog, input logic ack);
    endpoint = 4'd0; direction_in = 1'b1; setup = 1'b0; transaction_active = 1'b1;
    tick(3);
    chk("pkt_toggle", data_toggle, tog);
    chk("pkt_valid_start", data_in_valid, n > 0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("byte_%0d", a0 + i), data_in, rom_byte(a0 + i));
      data_strobe = 1'b1;
      tick(1);
      data_strobe = 1'b0;
      tick(3);
    end
    chk("pkt_valid_end", data_in_valid, 0);
    if (ack) begin
      success = 1'b1;
      tick(1);
      success = 1'b0;
    end
    transaction_active = 1'b0;
    tick(2);
  endtask

  task automatic status_stage();
    endpoint = 4'd0; direction_in = 1'b0; setup = 1'b0; transaction_active = 1'b1;
    tick(1);
    chk("status_no_early_done", done, 0);
    success = 1'b1;
    tick(1);
    success = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_clear", busy, 0);
    transaction_active = 1'b0;
    tick(1);
    chk("done_single", done, 0);
    chk("hs_nak_idle", handshake, 2'b10);
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = rom_byte(i);

    // Reset state
    rst = 1'b0;
    tick(3);
    chk("rst_data_in", data_in, 0);
    chk("rst_valid", data_in_valid, 0);
    chk("rst_toggle", data_toggle, 0);
    chk("rst_hs", handshake, 2'b10);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b1;
    tick(2);

    // 18-byte descriptor, wLength 64: 8,8,2 with toggles 1,0,1
    do_start(8'd0, 8'd18, 16'd64);
    in_packet(8, 0, 1'b1, 1'b1);
    in_packet(8, 8, 1'b0, 1'b1);
    in_packet(2, 16, 1'b1, 1'b1);
    status_stage();

    // wLength 9 truncates: 8 then 1 byte, no ZLP
    do_start(8'd0, 8'd18, 16'd9);
    in_packet(8, 0, 1'b1, 1'b1);
    in_packet(1, 8, 1'b0, 1'b1);
    status_stage();

    // 16 bytes at offset 36, wLength 255: 8, 8, ZLP
    do_start(8'd36, 8'd16, 16'd255);
    in_packet(8, 36, 1'b1, 1'b1);
    in_packet(8, 44, 1'b0, 1'b1);
    in_packet(0, 52, 1'b1, 1'b1);
    status_stage();

    // Retry: unacknowledged packet is resent, then abort by SETUP
    do_start(8'd0, 8'd18, 16'd64);
    in_packet(8, 0, 1'b1, 1'b0);
    in_packet(8, 0, 1'b1, 1'b1);
    in_packet(8, 8, 1'b0, 1'b1);
    endpoint = 4'd0; direction_in = 1'b0; setup = 1'b1; transaction_active = 1'b1;
    tick(1);
    chk("abort_busy", busy, 0);
    chk("abort_hs", handshake, 2'b10);
    chk("abort_no_done", done, 0);
    transaction_active = 1'b0; setup = 1'b0;
    tick(2);
    chk("abort_no_done_later", done, 0);

    // Restart after abort begins again at byte 0 with toggle 1
    do_start(8'd0, 8'd18, 16'd64);
    in_packet(8, 0, 1'b1, 1'b1);

    // Bus reset in the middle of streaming
    direction_in = 1'b1; transaction_active = 1'b1;
    tick(3);
    chk("mid_valid", data_in_valid, 1);
    chk("mid_byte8", data_in, rom_byte(8));
    data_strobe = 1'b1;
    tick(1);
    data_strobe = 1'b0;
    tick(3);
    chk("mid_byte9", data_in, rom_byte(9));
    usb_rst = 1'b1;
    tick(1);
    usb_rst = 1'b0;
    chk("usbrst_valid", data_in_valid, 0);
    chk("usbrst_busy", busy, 0);
    chk("usbrst_hs", handshake, 2'b10);
    transaction_active = 1'b0;
    tick(2);
    transaction_active = 1'b1;
    tick(3);
    chk("post_rst_in_valid", data_in_valid, 0);
    chk("post_rst_in_hs", handshake, 2'b10);
    chk("post_rst_in_busy", busy, 0);
    transaction_active = 1'b0;
    tick(2);

    // start coincident with usb_rst is dropped
    desc_len = 8'd18; req_len = 16'd64; start = 1'b1; usb_rst = 1'b1;
    tick(1);
    start = 1'b0; usb_rst = 1'b0;
    tick(1);
    chk("start_vs_usbrst_busy", busy, 0);
    chk("start_vs_usbrst_hs", handshake, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
